// File: rtl/modexp_controller.sv
// Modular exponentiation sequencer: constant-time left-to-right square-and-multiply
// driving one shared external combinational modular multiplier.
module modexp_controller #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned EXP_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] base,
   input  logic [EXP_WIDTH-1:0]  exponent,
   input  logic [DATA_WIDTH-1:0] modulant,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] result,
   output logic [DATA_WIDTH-1:0] mul_a,
   output logic [DATA_WIDTH-1:0] mul_b,
   output logic [DATA_WIDTH-1:0] mul_modulant,
   input  logic [DATA_WIDTH-1:0] mul_out
);

   localparam int unsigned IdxW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
   localparam logic [IdxW-1:0] IdxTop = IdxW'(EXP_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StSquare, StMult, StDone} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] base_q;
   logic [EXP_WIDTH-1:0]  exp_q;
   logic [DATA_WIDTH-1:0] mod_q;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [IdxW-1:0]       idx_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] mult_sel;

   // The multiply is always issued; only the write-back depends on the exponent bit.
   assign mult_sel = exp_q[idx_q] ? mul_out : acc_q;

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      unique case (state_q)
         StSquare: begin
            mul_a = acc_q;
            mul_b = acc_q;
         end
         StMult: begin
            mul_a = acc_q;
            mul_b = base_q;
         end
         default: ;
      endcase
   end

   assign busy         = (state_q == StSquare) || (state_q == StMult);
   assign done         = (state_q == StDone);
   assign err          = err_q;
   assign result       = result_q;
   assign mul_modulant = mod_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         base_q   <= '0;
         exp_q    <= '0;
         mod_q    <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  base_q <= base;
                  exp_q  <= exponent;
                  mod_q  <= modulant;
                  err_q  <= 1'b0;
                  acc_q  <= DATA_WIDTH'(1);
                  idx_q  <= IdxTop;
                  if (modulant == '0) begin
                     result_q <= '0;
                     err_q    <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     state_q <= StSquare;
                  end
               end
            end
            StSquare: begin
               acc_q   <= mul_out;
               state_q <= StMult;
            end
            StMult: begin
               acc_q <= mult_sel;
               if (idx_q == '0) begin
                  result_q <= mult_sel;
                  state_q  <= StDone;
               end else begin
                  idx_q   <= idx_q - 1'b1;
                  state_q <= StSquare;
               end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_modexp_controller.sv
// Directed bench for modexp_controller with a behavioural modular multiplier attached.
module tb_modexp_controller;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [7:0] base, modulant, result, mul_a, mul_b, mul_modulant, mul_out;
   logic [7:0] exponent;
   logic       busy, done, err;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   assign mul_out = (mul_modulant == 8'd0) ? 8'd0 :
                    8'((16'(mul_a) * 16'(mul_b)) % 16'(mul_modulant));

   modexp_controller #(.DATA_WIDTH(8), .EXP_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
      .modulant(modulant), .busy(busy), .done(done), .err(err), .result(result),
      .mul_a(mul_a), .mul_b(mul_b), .mul_modulant(mul_modulant), .mul_out(mul_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and waits (bounded) for done; lat = -1 on timeout.
   task automatic run_op(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                         output int lat, output logic [7:0] res, output logic er,
                         output logic saw_busy);
      base = b; exponent = e; modulant = m; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      saw_busy = 1'b0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) saw_busy = 1'b1;
         tick();
         lat++;
      end
      if (busy === 1'b1) saw_busy = 1'b1;
      res = result;
      er = err;
      if (done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; base = 8'd0; exponent = 8'd0; modulant = 8'd0;
      tick(); tick();
      reset = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err); end
      total++; if (result !== 8'd0) begin bad++; $display("FAIL reset_result: got %0d expected 0", result); end
      total++;
      if (mul_a !== 8'd0 || mul_b !== 8'd0) begin
         bad++; $display("FAIL reset_mul: got a=%0d b=%0d expected 0 0", mul_a, mul_b);
      end
   endtask

   task automatic test_basic();
      logic [7:0] acc;
      logic [7:0] e;
      e = 8'd5;
      acc = 8'd1;
      base = 8'd3; exponent = e; modulant = 8'd7; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         total++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL basic_sq_flags bit%0d: got busy=%b done=%b expected 1 0", i, busy, done);
         end
         total++;
         if (mul_a !== acc || mul_b !== acc) begin
            bad++; $display("FAIL basic_sq_ops bit%0d: got %0d,%0d expected %0d,%0d", i, mul_a, mul_b, acc, acc);
         end
         acc = 8'((16'(acc) * 16'(acc)) % 16'd7);
         tick();
         total++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL basic_mul_flags bit%0d: got busy=%b done=%b expected 1 0", i, busy, done);
         end
         total++;
         if (mul_a !== acc || mul_b !== 8'd3) begin
            bad++; $display("FAIL basic_mul_ops bit%0d: got %0d,%0d expected %0d,3", i, mul_a, mul_b, acc);
         end
         if (e[i]) acc = 8'((16'(acc) * 16'd3) % 16'd7);
         tick();
      end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b expected 1 at N+17", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
      total++; if (result !== 8'd5) begin bad++; $display("FAIL basic_result: got %0d expected 5", result); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b expected 0", err); end
      total++;
      if (mul_a !== 8'd0 || mul_b !== 8'd0 || mul_modulant !== 8'd7) begin
         bad++; $display("FAIL basic_done_mul: got a=%0d b=%0d m=%0d expected 0 0 7", mul_a, mul_b, mul_modulant);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL basic_after_done: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_values();
      logic [7:0] vb [4] = '{8'd255, 8'd9, 8'd5, 8'd200};
      logic [7:0] ve [4] = '{8'd255, 8'd0, 8'd3, 8'd1};
      logic [7:0] vm [4] = '{8'd251, 8'd11, 8'd1, 8'd7};
      logic [7:0] vr [4] = '{8'd20, 8'd1, 8'd0, 8'd4};
      int lat;
      logic [7:0] res;
      logic er, sb;
      for (int k = 0; k < 4; k++) begin
         run_op(vb[k], ve[k], vm[k], lat, res, er, sb);
         total++; if (lat !== 17) begin bad++; $display("FAIL values_lat%0d: got %0d expected 17", k, lat); end
         total++; if (res !== vr[k]) begin bad++; $display("FAIL values_result%0d: got %0d expected %0d", k, res, vr[k]); end
         total++; if (er !== 1'b0) begin bad++; $display("FAIL values_err%0d: got %b expected 0", k, er); end
         tick();
      end
   endtask

   task automatic test_mod_zero();
      int lat;
      logic [7:0] res;
      logic er, sb;
      run_op(8'd77, 8'hA5, 8'd0, lat, res, er, sb);
      total++; if (lat !== 1) begin bad++; $display("FAIL modzero_lat: got %0d expected 1", lat); end
      total++; if (er !== 1'b1) begin bad++; $display("FAIL modzero_err: got %b expected 1", er); end
      total++; if (res !== 8'd0) begin bad++; $display("FAIL modzero_result: got %0d expected 0", res); end
      total++; if (sb !== 1'b0) begin bad++; $display("FAIL modzero_busy: got %b expected 0", sb); end
      total++;
      if (mul_a !== 8'd0 || mul_b !== 8'd0) begin
         bad++; $display("FAIL modzero_mul: got a=%0d b=%0d expected 0 0", mul_a, mul_b);
      end
      tick();
      total++; if (err !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL modzero_hold: got err=%b done=%b expected 1 0", err, done); end
      run_op(8'd3, 8'd5, 8'd7, lat, res, er, sb);
      total++; if (er !== 1'b0) begin bad++; $display("FAIL modzero_clear: got err=%b expected 0", er); end
      total++; if (res !== 8'd5 || lat !== 17) begin bad++; $display("FAIL modzero_next: got %0d lat %0d expected 5 lat 17", res, lat); end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      base = 8'd3; exponent = 8'd5; modulant = 8'd7; start = 1'b1;
      tick();
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         base = 8'(lat * 13 + 1); exponent = 8'(lat * 7); modulant = 8'(lat + 2);
         if (lat == 8) begin
            total++;
            if (mul_modulant !== 8'd7) begin bad++; $display("FAIL b2b_latched_mod: got %0d expected 7", mul_modulant); end
         end
         tick();
         lat++;
      end
      total++; if (done !== 1'b1 || lat !== 17) begin bad++; $display("FAIL b2b_first_lat: got %0d expected 17", lat); end
      total++; if (result !== 8'd5) begin bad++; $display("FAIL b2b_first_result: got %0d expected 5", result); end
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL b2b_done_start_ignored: got busy=%b done=%b expected 0 0", busy, done);
      end
      base = 8'd2; exponent = 8'd3; modulant = 8'd5;
      tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept: got busy=%b expected 1", busy); end
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         base = 8'(lat * 5 + 3); exponent = 8'(lat * 11); modulant = 8'(lat + 9);
         tick();
         lat++;
      end
      start = 1'b0;
      total++; if (done !== 1'b1 || lat !== 17) begin bad++; $display("FAIL b2b_second_lat: got %0d expected 17", lat); end
      total++; if (result !== 8'd3) begin bad++; $display("FAIL b2b_second_result: got %0d expected 3", result); end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      logic [7:0] res;
      logic er, sb;
      base = 8'd3; exponent = 8'd5; modulant = 8'd7; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midreset_flags: got busy=%b done=%b expected 0 0", busy, done); end
      total++; if (result !== 8'd0) begin bad++; $display("FAIL midreset_result: got %0d expected 0", result); end
      total++; if (mul_a !== 8'd0 || mul_b !== 8'd0) begin bad++; $display("FAIL midreset_mul: got a=%0d b=%0d expected 0 0", mul_a, mul_b); end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1 || busy === 1'b1) seen++;
         tick();
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", seen); end
      run_op(8'd3, 8'd5, 8'd7, lat, res, er, sb);
      total++; if (res !== 8'd5 || lat !== 17) begin bad++; $display("FAIL midreset_rerun: got %0d lat %0d expected 5 lat 17", res, lat); end
      tick();
      reset = 1'b1; start = 1'b1;
      tick();
      reset = 1'b0; start = 1'b0;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_start_same: got busy=%b done=%b expected 0 0", busy, done); end
      tick();
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_start_dropped: got busy=%b done=%b expected 0 0", busy, done); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_values();
      test_mod_zero();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/modexp_controller.md
# modexp_controller

Sequencer that computes base^exponent mod modulant by driving one shared combinational modular multiplier (a*b % modulant) through a constant-time left-to-right square-and-multiply schedule. It sits between the crypto top level and the single multiplier instance. It owns the operand muxing, the accumulator and the exponent bit counter, and presents a start/busy/done handshake upstream.

## Interface
- DATA_WIDTH, 8: width of base, modulant, result and multiplier operands.
- EXP_WIDTH, 8: width of exponent; sets the number of iterations.

- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- base  input  DATA_WIDTH  operand, latched on accepted start; may be >= modulant.
- exponent  input  EXP_WIDTH  latched on accepted start.
- modulant  input  DATA_WIDTH  latched on accepted start.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse, result valid.
- err  output  1  high with done when latched modulant was 0; held until next accepted start.
- result  output  DATA_WIDTH  final value; held until next accepted start.
- mul_a, mul_b  output  DATA_WIDTH  operands to shared multiplier.
- mul_modulant  output  DATA_WIDTH  modulus to multiplier (= latched modulant).
- mul_out  input  DATA_WIDTH  multiplier result, combinational from mul_a/mul_b/mul_modulant.

## Operation
- States: IDLE, SQUARE, MULT, DONE.
- Registers: base_r, exp_r, mod_r, acc (DATA_WIDTH), bit index idx (counts EXP_WIDTH-1 down to 0), result, err.
- IDLE: on start=1, latch base/exponent/modulant, clear err, acc <= 1, idx <= EXP_WIDTH-1.
  - If modulant == 0, go to DONE with result <= 0 and err <= 1.
  - Otherwise go to SQUARE.
- IDLE with start=0: no state change.
- SQUARE: mul_a = mul_b = acc; acc <= mul_out; go to MULT.
- MULT: mul_a = acc, mul_b = base_r.
  - acc <= exp_r[idx] ? mul_out : acc. The multiply is always issued (constant time).
  - If idx == 0: result <= selected value, go to DONE.
  - Else: idx <= idx-1, go to SQUARE.
- DONE: done = 1 for exactly this cycle, then unconditionally to IDLE. start in DONE is ignored.
- mul_a/mul_b are 0 in IDLE and DONE. mul_modulant = mod_r in all states.
- start while busy or in DONE: ignored, latched operands unchanged.
- Arithmetic: every acc update comes from mul_out, so all values are reduced mod m.
  - acc starts at 1, so modulant == 1 yields 0.
  - exponent == 0 yields 1 % modulant.
  - base >= modulant is legal.
  - The controller never passes modulant == 0 to a multiply: mul_a/mul_b stay 0 on that path.

## Timing
- Accepted start in cycle N (IDLE, start=1).
- Normal path:
  - busy = 1 in cycles N+1 .. N+2*EXP_WIDTH.
  - SQUARE/MULT alternate, starting with SQUARE at N+1.
  - done = 1 and result valid in cycle N+2*EXP_WIDTH+1.
  - IDLE again at N+2*EXP_WIDTH+2.
  - Latency is independent of exponent value: 17 cycles start-to-done for EXP_WIDTH = 8.
- modulant == 0 path: done = 1 and err = 1 in cycle N+1; busy never asserts.
- Earliest next accepted start is the cycle after done.
- Outputs busy, done, err are registered or decoded from state only, never from inputs.
- Reset (any state, including mid-computation): next cycle state = IDLE.
  - busy = 0, done = 0, err = 0, result = 0, acc = 0, idx = 0; mul_a = mul_b = 0.
  - A computation interrupted by reset never produces done.
- Reset and start asserted together: reset wins, start is dropped.

## Test plan
- base=3, exponent=5, modulant=7, start at cycle N: busy for N+1..N+16, done at N+17 with result=5, err=0. Check mul_a/mul_b alternate acc,acc / acc,base.
- base=255, exponent=255, modulant=251: result=20; base=9, exponent=0, modulant=11: result=1. Both take 17 cycles.
- base=5, exponent=3, modulant=1: result=0. base=200, exponent=1, modulant=7: result=4 (base >= modulant).
- modulant=0, any base/exponent: done and err at N+1, result=0, busy never high. The next valid start clears err.
- Start pulsed every cycle with changing operands during a 3^5 mod 7 run: only the first request is accepted, result=5. The next request is accepted only in the cycle after done.
- Reset asserted in cycle N+6 of a run: IDLE, busy=0, result=0 next cycle, no done pulse. A fresh 3^5 mod 7 afterwards returns 5 in 17 cycles.
